// File: rtl/idct_frame_ctrl.sv
// Frame sequencer for the 8-point 1D-IDCT datapath: load 8 coefficients, run the pipeline, drain 8 results.
// Build option IDCT_SIGNMAG_EN: results leave in sign-magnitude form instead of two's complement.
module idct_frame_ctrl #(
    parameter int IN_W       = 8,
    parameter int OUT_W      = 39,
    parameter int PIPE_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    output logic             coef_we,
    output logic [2:0]       coef_idx,
    output logic [IN_W-1:0]  coef_data,
    output logic             dp_run,
    output logic             dp_clr,
    output logic [2:0]       res_sel,
    input  logic [OUT_W-1:0] res_data,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic [2:0]       out_idx,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);
    localparam int RUN_W = $clog2(PIPE_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, CLEAR} state_t;

    state_t           state_reg;
    logic [2:0]       cnt_reg;
    logic [RUN_W-1:0] run_cnt_reg;
    logic [OUT_W-1:0] res_conv;
    logic             accept;

    assign in_ready = ((state_reg == IDLE) || (state_reg == LOAD)) && !abort;
    assign accept   = in_valid && in_ready;

`ifdef IDCT_SIGNMAG_EN
    logic [OUT_W-1:0] res_neg;
    assign res_neg = -res_data;

    // The most negative value has no positive twin, so it saturates to full-scale magnitude.
    always_comb begin
        res_conv = res_data;
        if (res_data[OUT_W-1]) begin
            if (res_data[OUT_W-2:0] == '0)
                res_conv = {1'b1, {(OUT_W-1){1'b1}}};
            else
                res_conv = {1'b1, res_neg[OUT_W-2:0]};
        end
    end
`else
    assign res_conv = res_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            run_cnt_reg <= '0;
            coef_we     <= 1'b0;
            coef_idx    <= '0;
            coef_data   <= '0;
            dp_run      <= 1'b0;
            dp_clr      <= 1'b0;
            res_sel     <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_idx     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            coef_we <= 1'b0;
            dp_clr  <= 1'b0;
            done    <= 1'b0;
            if (abort) begin
                state_reg   <= CLEAR;
                busy        <= 1'b1;
                dp_clr      <= 1'b1;
                dp_run      <= 1'b0;
                out_valid   <= 1'b0;
                cnt_reg     <= '0;
                run_cnt_reg <= '0;
                res_sel     <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (accept) begin
                            coef_we   <= 1'b1;
                            coef_idx  <= 3'd0;
                            coef_data <= in_data;
                            cnt_reg   <= 3'd1;
                            state_reg <= LOAD;
                            busy      <= 1'b1;
                        end
                    end
                    LOAD: begin
                        if (accept) begin
                            coef_we   <= 1'b1;
                            coef_idx  <= cnt_reg;
                            coef_data <= in_data;
                            if (cnt_reg == 3'd7) begin
                                cnt_reg     <= '0;
                                run_cnt_reg <= '0;
                                state_reg   <= RUN;
                            end else begin
                                cnt_reg <= cnt_reg + 3'd1;
                            end
                        end
                    end
                    // First RUN cycle lets the beat-7 write land before the pipeline is enabled.
                    RUN: begin
                        if (run_cnt_reg == RUN_W'(PIPE_DEPTH)) begin
                            dp_run      <= 1'b0;
                            run_cnt_reg <= '0;
                            res_sel     <= 3'd0;
                            state_reg   <= DRAIN;
                        end else begin
                            dp_run      <= 1'b1;
                            run_cnt_reg <= run_cnt_reg + 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (!out_valid) begin
                            out_valid <= 1'b1;
                            out_data  <= res_conv;
                            out_idx   <= res_sel;
                        end else if (out_ready) begin
                            out_valid <= 1'b0;
                            if (out_idx == 3'd7) begin
                                done      <= 1'b1;
                                res_sel   <= 3'd0;
                                state_reg <= IDLE;
                                busy      <= 1'b0;
                            end else begin
                                res_sel <= res_sel + 3'd1;
                            end
                        end
                    end
                    CLEAR: begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_idct_frame_ctrl.sv
// Directed bench for idct_frame_ctrl with a combinational datapath result model.
module tb_idct_frame_ctrl;
    logic        clk;
    logic        rst_n;
    logic        abort;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        coef_we;
    logic [2:0]  coef_idx;
    logic [7:0]  coef_data;
    logic        dp_run;
    logic        dp_clr;
    logic [2:0]  res_sel;
    logic [38:0] res_data;
    logic        out_valid;
    logic [38:0] out_data;
    logic [2:0]  out_idx;
    logic        out_ready;
    logic        busy;
    logic        done;

    logic [38:0] h_mem [8];
    logic [38:0] exp_h [8];
    logic [7:0]  beat_v [8];
    int checks = 0;
    int errors = 0;

    idct_frame_ctrl dut (
        .clk(clk), .rst_n(rst_n), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .coef_we(coef_we), .coef_idx(coef_idx), .coef_data(coef_data),
        .dp_run(dp_run), .dp_clr(dp_clr), .res_sel(res_sel), .res_data(res_data),
        .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    assign res_data = h_mem[res_sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_beats(input int first, input int n);
        for (int k = first; k < first + n; k++) begin
            in_valid = 1'b1;
            in_data  = beat_v[k];
            tick();
            chk("coef_we", coef_we, 1);
            chk("coef_idx", coef_idx, k);
            chk("coef_data", coef_data, beat_v[k]);
            $display("coef write idx=%0d data=%0h", coef_idx, coef_data);
        end
    endtask

    task automatic run_phase();
        chk("run_entry_dp_run", dp_run, 0);
        chk("run_entry_busy", busy, 1);
        chk("run_entry_in_ready", in_ready, 0);
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("dp_run_high", dp_run, 1);
            chk("run_in_ready", in_ready, 0);
            chk("run_coef_we", coef_we, 0);
        end
        tick();
        chk("dp_run_low", dp_run, 0);
        chk("drain_entry_out_valid", out_valid, 0);
        chk("drain_entry_res_sel", res_sel, 0);
        tick();
        chk("first_out_latency", out_valid, 1);
    endtask

    task automatic drain(input int stall_idx);
        int n;
        for (int k = 0; k < 8; k++) begin
            n = 0;
            while (out_valid !== 1'b1 && n < 20) begin
                chk("drain_in_ready", in_ready, 0);
                tick();
                n++;
            end
            chk("out_valid", out_valid, 1);
            chk("out_idx", out_idx, k);
            chk("out_data", out_data, exp_h[k]);
            chk("drain_in_ready", in_ready, 0);
            $display("result idx=%0d data=%0h", out_idx, out_data);
            if (k == stall_idx) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    chk("stall_out_valid", out_valid, 1);
                    chk("stall_out_idx", out_idx, k);
                    chk("stall_out_data", out_data, exp_h[k]);
                end
                out_ready = 1'b1;
            end
            tick();
            if (k < 7) begin
                chk("resample_bubble", out_valid, 0);
                chk("no_early_done", done, 0);
            end else begin
                chk("done_pulse", done, 1);
                chk("done_busy", busy, 0);
                chk("done_in_ready", in_ready, 1);
            end
        end
        tick();
        chk("done_cleared", done, 0);
    endtask

    initial begin
        rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) h_mem[i] = 39'(i + 1);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_coef_we", coef_we, 0);
        chk("rst_coef_idx", coef_idx, 0);
        chk("rst_coef_data", coef_data, 0);
        chk("rst_dp_run", dp_run, 0);
        chk("rst_dp_clr", dp_clr, 0);
        chk("rst_res_sel", res_sel, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk) rst_n = 1'b1;

        // Frame 1: impulse frame, results k+1, sink always ready
        beat_v = '{8'd64, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        for (int i = 0; i < 8; i++) exp_h[i] = 39'(i + 1);
        send_beats(0, 8);
        in_valid = 1'b0;
        run_phase();
        drain(-1);

        // Abort after three accepted beats
        beat_v = '{8'hFD, 8'h05, 8'h7F, 8'h80, 8'h01, 8'h02, 8'h03, 8'h04};
        send_beats(0, 3);
        abort = 1'b1;
        #1;
        chk("abort_in_ready", in_ready, 0);
        tick();
        abort = 1'b0;
        in_valid = 1'b0;
        chk("abort_dp_clr", dp_clr, 1);
        chk("abort_coef_we", coef_we, 0);
        chk("abort_busy", busy, 1);
        chk("abort_no_done", done, 0);
        tick();
        chk("clear_dp_clr_low", dp_clr, 0);
        chk("clear_busy", busy, 0);
        chk("clear_no_done", done, 0);
        chk("clear_in_ready", in_ready, 1);

        // Frame 2: negative results, most-negative boundary, stall at idx 3
        h_mem[0] = 39'h7FFFFFFFFB;
        h_mem[5] = 39'h4000000000;
        h_mem[6] = 39'h7FFFFFFFFF;
        exp_h[1] = 39'd2; exp_h[2] = 39'd3; exp_h[3] = 39'd4; exp_h[4] = 39'd5; exp_h[7] = 39'd8;
`ifdef IDCT_SIGNMAG_EN
        exp_h[0] = 39'h4000000005;
        exp_h[5] = 39'h7FFFFFFFFF;
        exp_h[6] = 39'h4000000001;
`else
        exp_h[0] = 39'h7FFFFFFFFB;
        exp_h[5] = 39'h4000000000;
        exp_h[6] = 39'h7FFFFFFFFF;
`endif
        send_beats(0, 8);
        in_valid = 1'b0;
        run_phase();
        drain(3);

        // Frame 3: in_valid held high across RUN/DRAIN; next beat taken right after done
        for (int i = 0; i < 8; i++) begin
            h_mem[i] = 39'(i + 1);
            exp_h[i] = 39'(i + 1);
        end
        beat_v = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        send_beats(0, 8);
        in_data = 8'h55;
        run_phase();
        drain(-1);
        chk("b2b_coef_we", coef_we, 1);
        chk("b2b_coef_idx", coef_idx, 0);
        chk("b2b_coef_data", coef_data, 8'h55);
        chk("b2b_busy", busy, 1);

        // Frame 4: reset asserted during RUN
        beat_v = '{8'h55, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27};
        send_beats(1, 7);
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("pre_reset_dp_run", dp_run, 1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dp_run", dp_run, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_dp_clr", dp_clr, 0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_busy", busy, 0);

        // Frame 5: clean frame after reset recovery
        beat_v = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_beats(0, 8);
        in_valid = 1'b0;
        run_phase();
        drain(-1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
